// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: owns the PC, fetches from a combinational ROM, predicts
// control flow with a direct-mapped history-bit table, and freezes on the halt word.
module if_fetch_stage #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter int unsigned BHT_ENTRIES = 8,
    parameter logic [15:0] HALT_WORD   = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    input  logic        upd_valid,
    input  logic [15:0] upd_pc,
    input  logic [15:0] upd_target,
    input  logic        upd_taken,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    output logic        ifid_valid,
    output logic [15:0] ifid_instr,
    output logic [15:0] ifid_pc,
    output logic [15:0] ifid_pc_inc,
    output logic        ifid_pred_taken,
    output logic [15:0] ifid_pred_target,
    output logic        halted
);
    localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

    typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_e;

    state_e      state_q, state_d;
    logic        halted_q, halted_d;
    logic [15:0] pc_q, pc_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [15:0] ifid_instr_q, ifid_instr_d;
    logic [15:0] ifid_pc_q, ifid_pc_d;
    logic [15:0] ifid_pc_inc_q, ifid_pc_inc_d;
    logic        ifid_pt_q, ifid_pt_d;
    logic [15:0] ifid_ptgt_q, ifid_ptgt_d;

    logic [BHT_ENTRIES-1:0] bht_vld_q, bht_vld_d;
    logic [BHT_ENTRIES-1:0] bht_hbit_q, bht_hbit_d;
    logic [15:0]            bht_tag_q [BHT_ENTRIES];
    logic [15:0]            bht_tag_d [BHT_ENTRIES];
    logic [15:0]            bht_tgt_q [BHT_ENTRIES];
    logic [15:0]            bht_tgt_d [BHT_ENTRIES];

    logic [IDX_W-1:0] lk_idx, upd_idx;
    logic             lk_hit, pred_taken;
    logic [15:0]      pred_target, pc_inc;

    assign pc_inc  = pc_q + 16'd1;
    assign upd_idx = upd_pc[IDX_W-1:0];

    // Lookup reads registered contents only, so a same-cycle update is not visible.
    always_comb begin
        lk_idx      = pc_q[IDX_W-1:0];
        lk_hit      = bht_vld_q[lk_idx] && (bht_tag_q[lk_idx] == pc_q);
        pred_taken  = lk_hit && bht_hbit_q[lk_idx];
        pred_target = pred_taken ? bht_tgt_q[lk_idx] : 16'h0000;
    end

    always_comb begin
        bht_vld_d  = bht_vld_q;
        bht_hbit_d = bht_hbit_q;
        bht_tag_d  = bht_tag_q;
        bht_tgt_d  = bht_tgt_q;
        if (upd_valid) begin
            bht_vld_d[upd_idx]  = 1'b1;
            bht_hbit_d[upd_idx] = upd_taken;
            bht_tag_d[upd_idx]  = upd_pc;
            bht_tgt_d[upd_idx]  = upd_target;
        end
    end

    always_comb begin
        state_d       = state_q;
        halted_d      = halted_q;
        pc_d          = pc_q;
        ifid_valid_d  = ifid_valid_q;
        ifid_instr_d  = ifid_instr_q;
        ifid_pc_d     = ifid_pc_q;
        ifid_pc_inc_d = ifid_pc_inc_q;
        ifid_pt_d     = ifid_pt_q;
        ifid_ptgt_d   = ifid_ptgt_q;
        if (redirect_valid) begin
            pc_d          = redirect_pc;
            state_d       = S_RUN;
            halted_d      = 1'b0;
            ifid_valid_d  = 1'b0;
            ifid_instr_d  = 16'h0000;
            ifid_pc_d     = 16'h0000;
            ifid_pc_inc_d = 16'h0000;
            ifid_pt_d     = 1'b0;
            ifid_ptgt_d   = 16'h0000;
        end else if (stall) begin
            // hold everything
        end else if (state_q == S_HALT) begin
            ifid_valid_d = 1'b0;
        end else begin
            ifid_valid_d  = 1'b1;
            ifid_instr_d  = imem_data;
            ifid_pc_d     = pc_q;
            ifid_pc_inc_d = pc_inc;
            if (imem_data == HALT_WORD) begin
                // Halt wins over any prediction; pc parks on the halt address.
                ifid_pt_d   = 1'b0;
                ifid_ptgt_d = 16'h0000;
                state_d     = S_HALT;
                halted_d    = 1'b1;
            end else begin
                ifid_pt_d   = pred_taken;
                ifid_ptgt_d = pred_target;
                pc_d        = pred_taken ? pred_target : pc_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_RUN;
            halted_q      <= 1'b0;
            pc_q          <= RESET_PC;
            ifid_valid_q  <= 1'b0;
            ifid_instr_q  <= 16'h0000;
            ifid_pc_q     <= 16'h0000;
            ifid_pc_inc_q <= 16'h0000;
            ifid_pt_q     <= 1'b0;
            ifid_ptgt_q   <= 16'h0000;
            bht_vld_q     <= '0;
            bht_hbit_q    <= '0;
            for (int i = 0; i < int'(BHT_ENTRIES); i++) begin
                bht_tag_q[i] <= 16'h0000;
                bht_tgt_q[i] <= 16'h0000;
            end
        end else begin
            state_q       <= state_d;
            halted_q      <= halted_d;
            pc_q          <= pc_d;
            ifid_valid_q  <= ifid_valid_d;
            ifid_instr_q  <= ifid_instr_d;
            ifid_pc_q     <= ifid_pc_d;
            ifid_pc_inc_q <= ifid_pc_inc_d;
            ifid_pt_q     <= ifid_pt_d;
            ifid_ptgt_q   <= ifid_ptgt_d;
            bht_vld_q     <= bht_vld_d;
            bht_hbit_q    <= bht_hbit_d;
            bht_tag_q     <= bht_tag_d;
            bht_tgt_q     <= bht_tgt_d;
        end
    end

    assign imem_addr        = pc_q;
    assign ifid_valid       = ifid_valid_q;
    assign ifid_instr       = ifid_instr_q;
    assign ifid_pc          = ifid_pc_q;
    assign ifid_pc_inc      = ifid_pc_inc_q;
    assign ifid_pred_taken  = ifid_pt_q;
    assign ifid_pred_target = ifid_ptgt_q;
    assign halted           = halted_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed steps then random traffic, all checked
// against a behavioural fetch model with a 256-word ROM.
module tb_if_fetch_stage;
    localparam int BHT_N = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, redirect_valid, upd_valid, upd_taken;
    logic [15:0] redirect_pc, upd_pc, upd_target;
    logic [15:0] imem_addr, imem_data;
    logic        ifid_valid, ifid_pred_taken, halted;
    logic [15:0] ifid_instr, ifid_pc, ifid_pc_inc, ifid_pred_target;

    logic [15:0] rom [256];
    int n_err = 0;
    int n_chk = 0;

    typedef struct {
        bit          v;
        logic [15:0] tag;
        logic [15:0] tgt;
        bit          taken;
    } bht_ent_t;

    bht_ent_t    mb [BHT_N];
    logic [15:0] m_pc, m_instr, m_ipc, m_inc, m_ptg;
    bit          m_halt, m_v, m_pt;

    if_fetch_stage #(.RESET_PC(16'h0000), .BHT_ENTRIES(8), .HALT_WORD(16'hFFFF)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc),
        .ifid_pc_inc(ifid_pc_inc), .ifid_pred_taken(ifid_pred_taken),
        .ifid_pred_target(ifid_pred_target), .halted(halted)
    );

    always #5 clk = ~clk;
    always_comb imem_data = rom[imem_addr[7:0]];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_pc = 16'h0000; m_halt = 0;
        m_v = 0; m_instr = 0; m_ipc = 0; m_inc = 0; m_pt = 0; m_ptg = 0;
        for (int i = 0; i < BHT_N; i++) mb[i] = '{0, 16'h0, 16'h0, 0};
    endtask

    // One clock of the fetch rules, evaluated on the inputs present before the edge.
    task automatic model_tick();
        int          idx;
        bit          pt;
        logic [15:0] ptg, word;
        idx  = int'(m_pc % 16'(BHT_N));
        pt   = mb[idx].v && (mb[idx].tag == m_pc) && mb[idx].taken;
        ptg  = pt ? mb[idx].tgt : 16'h0000;
        word = rom[m_pc[7:0]];
        if (redirect_valid) begin
            m_pc = redirect_pc; m_halt = 0;
            m_v = 0; m_instr = 0; m_ipc = 0; m_inc = 0; m_pt = 0; m_ptg = 0;
        end else if (stall) begin
        end else if (m_halt) begin
            m_v = 0;
        end else if (word == 16'hFFFF) begin
            m_v = 1; m_instr = word; m_ipc = m_pc; m_inc = m_pc + 16'd1;
            m_pt = 0; m_ptg = 0; m_halt = 1;
        end else begin
            m_v = 1; m_instr = word; m_ipc = m_pc; m_inc = m_pc + 16'd1;
            m_pt = pt; m_ptg = ptg;
            m_pc = pt ? ptg : m_pc + 16'd1;
        end
        if (upd_valid) mb[int'(upd_pc % 16'(BHT_N))] = '{1, upd_pc, upd_target, upd_taken};
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_addr"},   imem_addr,              m_pc);
        chk({tag, "_valid"},  {15'b0, ifid_valid},     {15'b0, m_v});
        chk({tag, "_instr"},  ifid_instr,              m_instr);
        chk({tag, "_pc"},     ifid_pc,                 m_ipc);
        chk({tag, "_pcinc"},  ifid_pc_inc,             m_inc);
        chk({tag, "_ptaken"}, {15'b0, ifid_pred_taken}, {15'b0, m_pt});
        chk({tag, "_ptgt"},   ifid_pred_target,        m_ptg);
        chk({tag, "_halted"}, {15'b0, halted},         {15'b0, m_halt});
    endtask

    task automatic step(input string tag);
        model_tick();
        @(posedge clk); #1;
        check_all(tag);
    endtask

    task automatic redirect_to(input logic [15:0] pc);
        redirect_valid = 1; redirect_pc = pc;
        step("redir");
        redirect_valid = 0;
    endtask

    initial begin
        logic [15:0] w;
        rst_n = 0; stall = 0; redirect_valid = 0; redirect_pc = 0;
        upd_valid = 0; upd_pc = 0; upd_target = 0; upd_taken = 0;
        for (int i = 0; i < 256; i++) begin
            w = 16'($urandom);
            if (w == 16'hFFFF) w = 16'h1234;
            rom[i] = w;
        end
        rom[8'h31] = 16'hFFFF;
        m_reset();
        #12;
        check_all("reset");
        rst_n = 1;

        repeat (5) step("seq");
        chk("seq_addr5", imem_addr, 16'h0005);

        stall = 1;
        repeat (3) begin
            step("stall");
            chk("stall_addr", imem_addr, 16'h0005);
        end
        stall = 0;
        step("unstall");
        chk("unstall_addr6", imem_addr, 16'h0006);
        step("unstall");
        chk("unstall_addr7", imem_addr, 16'h0007);

        redirect_to(16'h0041);
        chk("redir_addr", imem_addr, 16'h0041);
        chk("redir_bubble", {15'b0, ifid_valid}, 16'h0000);
        step("redir_next");
        chk("redir_ifidpc", ifid_pc, 16'h0041);
        stall = 1;
        redirect_to(16'h0041);
        stall = 0;
        chk("redirstall_addr", imem_addr, 16'h0041);
        chk("redirstall_bubble", {15'b0, ifid_valid}, 16'h0000);
        step("redirstall_next");
        chk("redirstall_ifidpc", ifid_pc, 16'h0041);

        upd_valid = 1; upd_pc = 16'h001D; upd_target = 16'h002F; upd_taken = 1;
        step("upd_t");
        upd_valid = 0;
        redirect_to(16'h001D);
        step("bht_hit");
        chk("bht_hit_addr", imem_addr, 16'h002F);
        chk("bht_hit_pt", {15'b0, ifid_pred_taken}, 16'h0001);
        chk("bht_hit_tgt", ifid_pred_target, 16'h002F);
        upd_valid = 1; upd_taken = 0;
        step("upd_nt");
        upd_valid = 0;
        redirect_to(16'h001D);
        step("bht_nt");
        chk("bht_nt_addr", imem_addr, 16'h001E);
        redirect_to(16'h0025);
        step("bht_alias");
        chk("bht_alias_addr", imem_addr, 16'h0026);
        chk("bht_alias_pt", {15'b0, ifid_pred_taken}, 16'h0000);

        redirect_to(16'h0031);
        step("halt");
        chk("halt_instr", ifid_instr, 16'hFFFF);
        chk("halt_valid", {15'b0, ifid_valid}, 16'h0001);
        upd_valid = 1; upd_pc = 16'h001D; upd_target = 16'h002F; upd_taken = 1;
        repeat (11) begin
            step("halted");
            upd_valid = 0;
            chk("halted_addr", imem_addr, 16'h0031);
            chk("halted_flag", {15'b0, halted}, 16'h0001);
        end
        redirect_to(16'h001F);
        chk("resume_halted", {15'b0, halted}, 16'h0000);
        step("resume");
        chk("resume_addr", imem_addr, 16'h0020);
        redirect_to(16'h001D);
        step("pre_rst_hit");
        chk("pre_rst_hit_addr", imem_addr, 16'h002F);
        redirect_to(16'h0031);
        step("halt2");

        rst_n = 0;
        #2;
        m_reset();
        check_all("midrst");
        chk("midrst_addr", imem_addr, 16'h0000);
        rst_n = 1;
        step("post_rst");
        redirect_to(16'h001D);
        step("post_rst_miss");
        chk("post_rst_miss_addr", imem_addr, 16'h001E);

        redirect_to(16'hFFFF);
        step("wrap");
        chk("wrap_inc", ifid_pc_inc, 16'h0000);
        chk("wrap_addr", imem_addr, 16'h0000);

        rom[8'h80] = 16'hFFFF;
        rom[8'hC0] = 16'hFFFF;
        for (int c = 0; c < 400; c++) begin
            stall          = ($urandom % 4) == 0;
            redirect_valid = ($urandom % 8) == 0;
            redirect_pc    = (($urandom % 16) == 0) ? 16'hFFFF : 16'($urandom_range(0, 255));
            upd_valid      = ($urandom % 3) == 0;
            upd_pc         = ($urandom % 2) ? m_pc : 16'($urandom_range(0, 63));
            upd_target     = 16'($urandom_range(0, 255));
            upd_taken      = ($urandom % 2) == 1;
            step("rand");
        end
        stall = 0; redirect_valid = 0; upd_valid = 0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- IF stage of the 6-stage pipeline (IF ID RR EX MM WB).
- Owns the PC and drives the address of the combinational instruction ROM (word-addressed, 16-bit).
- Latches the returned word into the IF/ID pipeline register.
- Predicts branch targets with a direct-mapped history-bit table (BHT), takes redirects from later stages, and freezes on the halt word.

Parameters:
- RESET_PC, 16'h0000, PC value after reset.
- BHT_ENTRIES, 8, number of BHT entries; power of two, 2..64.
- HALT_WORD, 16'hFFFF, instruction encoding that halts fetch.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold PC and IF/ID (ID or a later stage is busy).
- redirect_valid  in  1  mispredict, jump or R7-write correction from a later stage.
- redirect_pc  in  16  corrected fetch address.
- upd_valid  in  1  resolved control-flow instruction; update BHT.
- upd_pc  in  16  PC of the resolved instruction.
- upd_target  in  16  resolved target.
- upd_taken  in  1  actual outcome.
- imem_addr  out  16  ROM address; equals the PC register, combinational.
- imem_data  in  16  ROM data for imem_addr, valid in the same cycle.
- ifid_valid  out  1  IF/ID holds a real instruction.
- ifid_instr  out  16  latched instruction.
- ifid_pc  out  16  PC of the latched instruction.
- ifid_pc_inc  out  16  ifid_pc + 1 (link value for JAL/JLR).
- ifid_pred_taken  out  1  fetch predicted taken.
- ifid_pred_target  out  16  predicted target; 0 when not taken.
- halted  out  1  fetch frozen on HALT_WORD.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, state=RUN.
  - All ifid_* = 0; halted=0.
  - All BHT valid bits = 0.
  - Applies immediately and holds while rst_n=0. Reset mid-operation discards everything, including the HALT state and the BHT.
- Fetch: imem_addr=pc. One instruction per cycle; latency from PC to IF/ID output is 1 cycle.
- BHT lookup (combinational on pc):
  - idx = pc[log2(BHT_ENTRIES)-1:0].
  - hit = valid[idx] & (tag[idx]==pc).
  - pred_taken = hit & hbit[idx]; pred_target = target[idx] when taken, else 0.
- BHT update (on upd_valid):
  - Entry at upd_pc index is written: valid=1, tag=upd_pc, target=upd_target, hbit=upd_taken.
  - Written on every update, including a not-taken first encounter.
  - Same-index lookup and update in the same cycle: the lookup sees the old contents (no bypass).
  - Updates proceed during stall, HALT and redirect.
- Next-PC priority, per cycle:
  1. redirect_valid: pc<=redirect_pc; IF/ID loads a bubble (ifid_valid=0, other ifid_* = 0); state<=RUN; halted<=0. Redirect overrides stall.
  2. stall: pc and all ifid_* hold.
  3. state==HALT: pc holds; ifid_valid<=0.
  4. RUN and imem_data==HALT_WORD:
     - IF/ID loads the halt word with ifid_valid=1 for one cycle.
     - pc holds at the halt address; state<=HALT; halted<=1.
     - Halt takes priority over a BHT hit at the same pc.
  5. RUN, normal fetch:
     - IF/ID <= {1, imem_data, pc, pc+1, pred_taken, pred_target}.
     - pc <= pred_taken ? pred_target : pc+1.
- State machine: RUN→HALT on rule 4. HALT→RUN only on redirect_valid (a wrong-path halt word is cancelled) or reset.
- Arithmetic:
  - pc+1 is 16-bit and wraps: 16'hFFFF+1 = 16'h0000.
  - ifid_pc_inc is likewise modulo 2^16.
- Simultaneous redirect_valid and upd_valid: both take effect.
- The redirect source guarantees redirect_pc lies within the ROM; this block does no range check.

Test Plan:
- Reset release with sequential ROM:
  - imem_addr = 0,1,2,3 on successive cycles.
  - ifid_pc lags imem_addr by one cycle; ifid_valid=0 in the first cycle after reset, then 1.
  - ifid_pc_inc = ifid_pc+1.
- Stall for 3 cycles while pc=5:
  - imem_addr stays 5 and ifid_* are unchanged throughout.
  - After release, pc goes 6, 7.
- Redirect and redirect+stall:
  - redirect_valid with redirect_pc=16'h0041 → next imem_addr=0x41; ifid_valid=0 for exactly one cycle; the next ifid_pc=0x41.
  - Repeat with stall=1 asserted in the same cycle → same result.
- BHT predict, update and alias:
  - upd pc=0x1D, target=0x2F, taken=1; later fetch 0x1D → next imem_addr=0x2F, ifid_pred_taken=1, ifid_pred_target=0x2F.
  - upd with taken=0 → fetch 0x1D falls through to 0x1E, pred_taken=0.
  - Fetch of 0x25 (same index, different tag) → no prediction.
- Halt:
  - imem_data=16'hFFFF at pc=0x31 → ifid_instr=FFFF with valid=1 for one cycle, then ifid_valid=0.
  - halted=1 and imem_addr stuck at 0x31 for 10+ cycles.
  - redirect to 0x1F → halted=0, fetch resumes at 0x1F, 0x20.
- Reset mid-operation:
  - While HALT with the BHT populated, pulse rst_n low for a partial cycle → all outputs clear immediately and imem_addr=RESET_PC.
  - After release, the previously predicted pc falls through (BHT cleared).
